// File: rtl/dht11_poll_scheduler_if.sv
// rtl/dht11_poll_scheduler_if.sv - handshake between the poll scheduler and the dht11 reader
interface dht11_poll_scheduler_if;
    logic       rd_en;
    logic [7:0] rd_humidity;
    logic [7:0] rd_temperature;
    logic       rd_data_ready;

    modport master (
        output rd_en,
        input  rd_humidity,
        input  rd_temperature,
        input  rd_data_ready
    );

    modport slave (
        input  rd_en,
        output rd_humidity,
        output rd_temperature,
        output rd_data_ready
    );
endinterface

// File: rtl/dht11_poll_scheduler.sv
// rtl/dht11_poll_scheduler.sv - DHT11 poll/retry scheduler with held sample and hysteretic alarms
module dht11_poll_scheduler #(
    parameter int unsigned POLL_PERIOD_CYC = 200_000_000,
    parameter int unsigned TIMEOUT_CYC     = 3_000_000,
    parameter int unsigned RETRY_GAP_CYC   = 100_000_000,
    parameter int unsigned MAX_RETRY       = 3,
    parameter int unsigned TEMP_HI         = 8,
    parameter int unsigned TEMP_LO         = 2,
    parameter int unsigned HYST            = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable_i,
    input  logic                          force_poll_i,
    dht11_poll_scheduler_if.master        rd,
    output logic [7:0]                    humidity_o,
    output logic [7:0]                    temperature_o,
    output logic                          sample_valid_o,
    output logic                          fault_o,
    output logic                          alarm_hi_o,
    output logic                          alarm_lo_o,
    output logic [15:0]                   sample_count_o,
    output logic [7:0]                    err_count_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACQUIRE = 2'd1,
        S_GAP     = 2'd2,
        S_WAIT    = 2'd3
    } state_t;

    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYC - 1);
    localparam logic [31:0] GAP_LAST     = 32'(RETRY_GAP_CYC - 1);
    localparam logic [31:0] POLL_LAST    = 32'(POLL_PERIOD_CYC - 1);
    localparam logic [31:0] RETRY_LIMIT  = 32'(MAX_RETRY);

    // Thresholds widened to 9 bits so TEMP_LO+HYST cannot wrap; clear-high floors at 0.
    localparam logic [8:0] HI_SET = 9'(TEMP_HI);
    localparam logic [8:0] HI_CLR = (TEMP_HI >= HYST) ? 9'(TEMP_HI - HYST) : 9'd0;
    localparam logic [8:0] LO_SET = 9'(TEMP_LO);
    localparam logic [8:0] LO_CLR = 9'(TEMP_LO + HYST);

    state_t      state_q, state_d;
    logic [31:0] timer_q, timer_d;
    logic [7:0]  retry_q, retry_d;
    logic        rd_en_q;
    logic [7:0]  hum_q, hum_d;
    logic [7:0]  temp_q, temp_d;
    logic        sv_q, sv_d;
    logic        fault_q, fault_d;
    logic        hi_q, hi_d;
    logic        lo_q, lo_d;
    logic [15:0] scnt_q, scnt_d;
    logic [7:0]  ecnt_q, ecnt_d;
    logic [8:0]  t9;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q + 32'd1;
        retry_d = retry_q;
        hum_d   = hum_q;
        temp_d  = temp_q;
        sv_d    = 1'b0;
        fault_d = fault_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        scnt_d  = scnt_q;
        ecnt_d  = ecnt_q;
        t9      = {1'b0, rd.rd_temperature};

        if (!enable_i) begin
            state_d = S_IDLE;
            retry_d = '0;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_ACQUIRE;
                S_ACQUIRE: begin
                    // A good sample on the timeout cycle takes priority over the error path.
                    if (rd.rd_data_ready) begin
                        hum_d   = rd.rd_humidity;
                        temp_d  = rd.rd_temperature;
                        sv_d    = 1'b1;
                        scnt_d  = scnt_q + 16'd1;
                        fault_d = 1'b0;
                        retry_d = '0;
                        if (t9 > HI_SET)       hi_d = 1'b1;
                        else if (t9 <= HI_CLR) hi_d = 1'b0;
                        if (t9 < LO_SET)       lo_d = 1'b1;
                        else if (t9 >= LO_CLR) lo_d = 1'b0;
                        state_d = S_WAIT;
                    end else if (timer_q == TIMEOUT_LAST) begin
                        if (ecnt_q != 8'hFF) ecnt_d = ecnt_q + 8'd1;
                        if ((32'(retry_q) + 32'd1) == RETRY_LIMIT) begin
                            fault_d = 1'b1;
                            retry_d = '0;
                            state_d = S_WAIT;
                        end else begin
                            retry_d = retry_q + 8'd1;
                            state_d = S_GAP;
                        end
                    end
                end
                S_GAP: if (timer_q == GAP_LAST) state_d = S_ACQUIRE;
                S_WAIT: if (timer_q == POLL_LAST || force_poll_i) state_d = S_ACQUIRE;
                default: state_d = S_IDLE;
            endcase
        end

        if (state_d != state_q || state_d == S_IDLE) timer_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            retry_q <= '0;
            rd_en_q <= 1'b0;
            hum_q   <= '0;
            temp_q  <= '0;
            sv_q    <= 1'b0;
            fault_q <= 1'b0;
            hi_q    <= 1'b0;
            lo_q    <= 1'b0;
            scnt_q  <= '0;
            ecnt_q  <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            retry_q <= retry_d;
            rd_en_q <= (state_d == S_ACQUIRE);
            hum_q   <= hum_d;
            temp_q  <= temp_d;
            sv_q    <= sv_d;
            fault_q <= fault_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            scnt_q  <= scnt_d;
            ecnt_q  <= ecnt_d;
        end
    end

    assign rd.rd_en         = rd_en_q;
    assign humidity_o       = hum_q;
    assign temperature_o    = temp_q;
    assign sample_valid_o   = sv_q;
    assign fault_o          = fault_q;
    assign alarm_hi_o       = hi_q;
    assign alarm_lo_o       = lo_q;
    assign sample_count_o   = scnt_q;
    assign err_count_o      = ecnt_q;

endmodule

// File: tb/tb_dht11_poll_scheduler.sv
// tb/tb_dht11_poll_scheduler.sv - self-checking bench for dht11_poll_scheduler
module tb_dht11_poll_scheduler;

    localparam int POLL     = 1000;
    localparam int TIMEOUT  = 200;
    localparam int GAP      = 50;
    localparam int MAXR     = 3;
    localparam int TEMP_HI  = 8;
    localparam int TEMP_LO  = 2;
    localparam int HYST     = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        force_poll;
    logic [7:0]  humidity, temperature, err_count;
    logic        sample_valid, fault, alarm_hi, alarm_lo;
    logic [15:0] sample_count;

    dht11_poll_scheduler_if rd_if();

    dht11_poll_scheduler #(
        .POLL_PERIOD_CYC(POLL), .TIMEOUT_CYC(TIMEOUT), .RETRY_GAP_CYC(GAP),
        .MAX_RETRY(MAXR), .TEMP_HI(TEMP_HI), .TEMP_LO(TEMP_LO), .HYST(HYST)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable_i(enable), .force_poll_i(force_poll),
        .rd(rd_if),
        .humidity_o(humidity), .temperature_o(temperature), .sample_valid_o(sample_valid),
        .fault_o(fault), .alarm_hi_o(alarm_hi), .alarm_lo_o(alarm_lo),
        .sample_count_o(sample_count), .err_count_o(err_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // attempt-level reference model
    int m_hum, m_temp, m_samples, m_err, m_fails;
    bit m_fault, m_hi, m_lo, m_next_wait;

    typedef struct {
        int         d;
        bit         good;
        logic [7:0] h;
        logic [7:0] t;
        int         force_at;
        bit         exp_fault;
        bit         exp_hi;
        bit         exp_lo;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic model_good(input int h, input int t);
        int clr;
        m_hum = h; m_temp = t;
        m_samples = (m_samples + 1) % 65536;
        m_fault = 0; m_fails = 0; m_next_wait = 1;
        clr = TEMP_HI - HYST;
        if (clr < 0) clr = 0;
        if (t > TEMP_HI) m_hi = 1;
        else if (t <= clr) m_hi = 0;
        if (t < TEMP_LO) m_lo = 1;
        else if (t >= TEMP_LO + HYST) m_lo = 0;
    endtask

    task automatic model_timeout();
        if (m_err < 255) m_err++;
        m_fails++;
        if (m_fails == MAXR) begin
            m_fault = 1; m_fails = 0; m_next_wait = 1;
        end else begin
            m_next_wait = 0;
        end
    endtask

    task automatic check_held(input string tag);
        chk({tag, "_hum"},  32'(humidity),     m_hum);
        chk({tag, "_temp"}, 32'(temperature),  m_temp);
        chk({tag, "_scnt"}, 32'(sample_count), m_samples);
        chk({tag, "_ecnt"}, 32'(err_count),    m_err);
        chk({tag, "_fault"}, 32'(fault),       32'(m_fault));
        chk({tag, "_hi"},   32'(alarm_hi),     32'(m_hi));
        chk({tag, "_lo"},   32'(alarm_lo),     32'(m_lo));
    endtask

    // Entered at the negedge of the first rd_en-high cycle; returns at the first low cycle.
    task automatic attempt(input int d, input bit good, input logic [7:0] h, input logic [7:0] t,
                           input bit force_inside);
        int n;
        bit sv_bad;
        n = 1; sv_bad = 0;
        while (1) begin
            if (good && n == d) begin
                rd_if.rd_data_ready = 1'b1; rd_if.rd_humidity = h; rd_if.rd_temperature = t;
            end else begin
                rd_if.rd_humidity = 8'($urandom); rd_if.rd_temperature = 8'($urandom);
            end
            if (force_inside && n == 2) force_poll = 1'b1;
            @(negedge clk);
            rd_if.rd_data_ready = 1'b0; force_poll = 1'b0;
            if (!rd_if.rd_en) break;
            if (sample_valid) sv_bad = 1;
            n++;
            if (n > TIMEOUT + 10) break;
        end
        if (good) model_good(int'(h), int'(t));
        else model_timeout();
        chk("window_len", n, good ? d : TIMEOUT);
        chk("sv_in_window", 32'(sv_bad), 0);
        chk("sv_pulse", 32'(sample_valid), 32'(good));
        check_held("post");
    endtask

    // Entered at the first low cycle; returns at the negedge where rd_en is high again.
    task automatic wait_low(input int force_at);
        int cnt, exp_low;
        bit sv_bad;
        exp_low = m_next_wait ? ((force_at > 0 && force_at <= POLL) ? force_at : POLL) : GAP;
        cnt = 1; sv_bad = 0;
        while (1) begin
            if (cnt == force_at) force_poll = 1'b1;
            if ($urandom_range(0, 7) == 0) begin
                rd_if.rd_data_ready = 1'b1;
                rd_if.rd_humidity = 8'($urandom); rd_if.rd_temperature = 8'($urandom);
            end
            @(negedge clk);
            force_poll = 1'b0; rd_if.rd_data_ready = 1'b0;
            if (rd_if.rd_en) break;
            if (sample_valid) sv_bad = 1;
            cnt++;
            if (cnt > POLL + 10) break;
        end
        chk("low_len", cnt, exp_low);
        chk("sv_in_low", 32'(sv_bad), 0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog expired actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; enable = 1'b0; force_poll = 1'b0;
        rd_if.rd_data_ready = 1'b0; rd_if.rd_humidity = '0; rd_if.rd_temperature = '0;
        m_hum = 0; m_temp = 0; m_samples = 0; m_err = 0; m_fails = 0;
        m_fault = 0; m_hi = 0; m_lo = 0; m_next_wait = 0;

        tbl[0]  = '{100, 1'b1, 8'd45, 8'd5, 0,   1'b0, 1'b0, 1'b0};
        tbl[1]  = '{0,   1'b0, 8'd0,  8'd0, 5,   1'b0, 1'b0, 1'b0};
        tbl[2]  = '{0,   1'b0, 8'd0,  8'd0, 0,   1'b0, 1'b0, 1'b0};
        tbl[3]  = '{30,  1'b1, 8'd50, 8'd4, 0,   1'b0, 1'b0, 1'b0};
        tbl[4]  = '{0,   1'b0, 8'd0,  8'd0, 0,   1'b0, 1'b0, 1'b0};
        tbl[5]  = '{0,   1'b0, 8'd0,  8'd0, 0,   1'b0, 1'b0, 1'b0};
        tbl[6]  = '{0,   1'b0, 8'd0,  8'd0, 0,   1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1,   1'b1, 8'd60, 8'd9, 11,  1'b0, 1'b1, 1'b0};
        tbl[8]  = '{200, 1'b1, 8'd61, 8'd8, 0,   1'b0, 1'b1, 1'b0};
        tbl[9]  = '{57,  1'b1, 8'd62, 8'd7, 10,  1'b0, 1'b0, 1'b0};
        tbl[10] = '{80,  1'b1, 8'd63, 8'd1, 0,   1'b0, 1'b0, 1'b1};
        tbl[11] = '{150, 1'b1, 8'd64, 8'd2, 1,   1'b0, 1'b0, 1'b1};
        tbl[12] = '{199, 1'b1, 8'd65, 8'd3, 0,   1'b0, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        chk("reset_rd_en", 32'(rd_if.rd_en), 0);
        chk("reset_sv", 32'(sample_valid), 0);
        check_held("reset");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_rd_en", 32'(rd_if.rd_en), 0);

        enable = 1'b1;
        @(negedge clk);
        chk("first_acquire_immediate", 32'(rd_if.rd_en), 1);

        for (int i = 0; i < 13; i++) begin
            attempt(tbl[i].d, tbl[i].good, tbl[i].h, tbl[i].t, i == 3);
            chk("tbl_fault", 32'(fault), 32'(tbl[i].exp_fault));
            chk("tbl_hi", 32'(alarm_hi), 32'(tbl[i].exp_hi));
            chk("tbl_lo", 32'(alarm_lo), 32'(tbl[i].exp_lo));
            wait_low(tbl[i].force_at);
        end
        chk("tbl_err_total", 32'(err_count), 5);
        chk("tbl_scnt_total", 32'(sample_count), 8);

        // two failures, then enable dropped mid-window: retry count must restart
        attempt(0, 1'b0, 8'd0, 8'd0, 1'b0);
        wait_low(0);
        attempt(0, 1'b0, 8'd0, 8'd0, 1'b0);
        wait_low(0);
        repeat (20) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        chk("drop_rd_en_low", 32'(rd_if.rd_en), 0);
        rd_if.rd_data_ready = 1'b1; rd_if.rd_humidity = 8'd99; rd_if.rd_temperature = 8'd99;
        @(negedge clk);
        rd_if.rd_data_ready = 1'b0;
        m_fails = 0;
        chk("late_ready_sv", 32'(sample_valid), 0);
        check_held("late_ready");
        repeat (5) @(negedge clk);
        chk("idle_after_drop", 32'(rd_if.rd_en), 0);
        enable = 1'b1;
        @(negedge clk);
        chk("reenable_immediate", 32'(rd_if.rd_en), 1);
        attempt(0, 1'b0, 8'd0, 8'd0, 1'b0);
        chk("retry_cleared_no_fault", 32'(fault), 0);
        wait_low(7);
        attempt(40, 1'b1, 8'd70, 8'd5, 1'b0);
        wait_low(10);

        for (int i = 0; i < 30; i++) begin
            bit          g;
            int          d, fa;
            logic [7:0]  h, t;
            g  = ($urandom_range(0, 1) == 1);
            d  = $urandom_range(1, TIMEOUT);
            h  = 8'($urandom);
            t  = 8'($urandom_range(0, 12));
            fa = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 60);
            attempt(d, g, h, t, ($urandom_range(0, 1) == 1));
            wait_low(fa);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
